// File: rtl/friscv_pmp_checker_if.sv
// Request/response handshake bundle between a memory access unit and the PMP checker.
interface friscv_pmp_checker_if #(
  parameter int unsigned RLEN = 34,
  parameter int unsigned IXW  = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [RLEN-1:0] req_addr;
  logic [1:0]      req_type;
  logic            req_mmode;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_allow;
  logic            rsp_match;
  logic [IXW-1:0]  rsp_region;

  modport master (
    output req_valid, req_addr, req_type, req_mmode, rsp_ready,
    input  req_ready, rsp_valid, rsp_allow, rsp_match, rsp_region
  );

  modport slave (
    input  req_valid, req_addr, req_type, req_mmode, rsp_ready,
    output req_ready, rsp_valid, rsp_allow, rsp_match, rsp_region
  );
endinterface

// File: rtl/friscv_pmp_checker.sv
// Sequential PMP checker: scans one entry per cycle, lowest index wins, exits on first match.
module friscv_pmp_checker #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RLEN       = 34,
  parameter int unsigned NB_REGIONS = 16,
  parameter int unsigned IXW        = (NB_REGIONS > 1) ? $clog2(NB_REGIONS) : 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NB_REGIONS*XLEN-1:0] pmp_addr,
  input  logic [NB_REGIONS*8-1:0]    pmp_cfg,
  friscv_pmp_checker_if.slave        bus
);

  localparam int unsigned MaskW = XLEN + 3;
  localparam int unsigned WideW = (RLEN > MaskW) ? RLEN : MaskW;

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e          state_q, state_d;
  logic [IXW-1:0]  idx_q, idx_d;
  logic [RLEN-1:0] prev_top_q, prev_top_d;
  logic [RLEN-1:0] addr_q, addr_d;
  logic [1:0]      type_q, type_d;
  logic            mmode_q, mmode_d;
  logic            allow_q, allow_d;
  logic            match_q, match_d;
  logic [IXW-1:0]  region_q, region_d;

  logic [XLEN-1:0] entry_addr [NB_REGIONS];
  logic [7:0]      entry_cfg  [NB_REGIONS];

  for (genvar i = 0; i < NB_REGIONS; i++) begin : g_unpack
    assign entry_addr[i] = pmp_addr[i*XLEN +: XLEN];
    assign entry_cfg[i]  = pmp_cfg[i*8 +: 8];
  end

  logic [XLEN-1:0]  cur_addr;
  logic [7:0]       cur_cfg;
  logic [WideW-1:0] top_wide;
  logic [WideW-1:0] lowmask_wide;
  logic [XLEN:0]    addr_inc;
  logic [XLEN:0]    trail_ones;
  logic [RLEN-1:0]  top;
  logic [RLEN-1:0]  napot_mask;
  logic             hit;
  logic             perm;

  assign cur_addr = entry_addr[idx_q];
  assign cur_cfg  = entry_cfg[idx_q];

  assign top_wide = WideW'({cur_addr, 2'b00});
  assign top      = top_wide[RLEN-1:0];

  // a ^ (a+1) sets bits 0..t where t is the trailing-ones count; two more ones give the
  // t+3 low bits the NAPOT region ignores. All-ones a clears the mask entirely.
  assign addr_inc     = {1'b0, cur_addr} + (XLEN+1)'(1);
  assign trail_ones   = addr_inc ^ {1'b0, cur_addr};
  assign lowmask_wide = WideW'({trail_ones, 2'b11});
  assign napot_mask   = ~lowmask_wide[RLEN-1:0];

  always_comb begin
    hit = 1'b0;
    unique case (cur_cfg[4:3])
      2'b00: hit = 1'b0;
      2'b01: hit = (addr_q >= prev_top_q) && (addr_q < top);
      2'b10: hit = (addr_q[RLEN-1:2] == top[RLEN-1:2]);
      2'b11: hit = ((addr_q & napot_mask) == (top & napot_mask));
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    perm = cur_cfg[0];
    unique case (type_q)
      2'd1:    perm = cur_cfg[1];
      2'd2:    perm = cur_cfg[2];
      default: perm = cur_cfg[0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    prev_top_d = prev_top_q;
    addr_d     = addr_q;
    type_d     = type_q;
    mmode_d    = mmode_q;
    allow_d    = allow_q;
    match_d    = match_q;
    region_d   = region_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d     = bus.req_addr;
          type_d     = bus.req_type;
          mmode_d    = bus.req_mmode;
          idx_d      = '0;
          prev_top_d = '0;
          state_d    = StScan;
        end
      end
      StScan: begin
        if (hit) begin
          match_d  = 1'b1;
          region_d = idx_q;
          allow_d  = (mmode_q && !cur_cfg[7]) ? 1'b1 : perm;
          state_d  = StResp;
        end else begin
          // TOR bottom comes from the previous entry regardless of its A field.
          prev_top_d = top;
          idx_d      = idx_q + IXW'(1);
          if (idx_q == IXW'(NB_REGIONS - 1)) begin
            match_d  = 1'b0;
            region_d = '0;
            allow_d  = mmode_q;
            state_d  = StResp;
          end
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      prev_top_q <= '0;
      addr_q     <= '0;
      type_q     <= '0;
      mmode_q    <= 1'b0;
      allow_q    <= 1'b0;
      match_q    <= 1'b0;
      region_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prev_top_q <= prev_top_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      mmode_q    <= mmode_d;
      allow_q    <= allow_d;
      match_q    <= match_d;
      region_q   <= region_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_allow  = allow_q;
  assign bus.rsp_match  = match_q;
  assign bus.rsp_region = region_q;

  logic unused_bits;
  assign unused_bits = ^{top_wide, lowmask_wide, cur_cfg[6:5]};

endmodule

// File: tb/tb_friscv_pmp_checker.sv
// Randomised and directed check of the PMP checker against an address-range reference model.
module tb_friscv_pmp_checker;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RLEN = 34;
  localparam int unsigned NB   = 16;
  localparam int unsigned IXW  = 4;

  logic aclk;
  logic aresetn;
  logic [NB*XLEN-1:0] pmp_addr;
  logic [NB*8-1:0]    pmp_cfg;

  logic [XLEN-1:0] csr_addr [NB];
  logic [7:0]      csr_cfg  [NB];

  int n_checks = 0;
  int n_bad    = 0;

  friscv_pmp_checker_if #(.RLEN(RLEN), .IXW(IXW)) bus ();

  friscv_pmp_checker #(
    .XLEN       (XLEN),
    .RLEN       (RLEN),
    .NB_REGIONS (NB),
    .IXW        (IXW)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .pmp_addr (pmp_addr),
    .pmp_cfg  (pmp_cfg),
    .bus      (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always_comb begin
    pmp_addr = '0;
    pmp_cfg  = '0;
    for (int i = 0; i < NB; i++) begin
      pmp_addr[i*XLEN +: XLEN] = csr_addr[i];
      pmp_cfg[i*8 +: 8]        = csr_cfg[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each entry describes a byte range [lo, hi); first entry containing addr wins.
  function automatic void model(input logic [RLEN-1:0] addr, input logic [1:0] typ,
                                input logic mm, output logic m, output int unsigned rgn,
                                output logic al);
    longint unsigned prev, a4, lo, hi, size, ad;
    int t;
    logic found;
    ad    = longint'(addr);
    prev  = 0;
    found = 1'b0;
    m     = 1'b0;
    rgn   = 0;
    al    = mm;
    for (int i = 0; i < NB; i++) begin
      if (!found) begin
        logic hitv, pbit;
        a4   = longint'(csr_addr[i]) * 4;
        hitv = 1'b0;
        case (csr_cfg[i][4:3])
          2'd1: hitv = (ad >= prev) && (ad < a4);
          2'd2: hitv = (ad >= a4) && (ad < a4 + 4);
          2'd3: begin
            t = 0;
            while (t < XLEN && csr_addr[i][t]) t++;
            size = 64'd1 << (t + 3);
            lo   = a4 & ~(size - 1);
            hi   = lo + size;
            hitv = (ad >= lo) && (ad < hi);
          end
          default: hitv = 1'b0;
        endcase
        if (hitv) begin
          found = 1'b1;
          m     = 1'b1;
          rgn   = i;
          pbit  = (typ == 2'd1) ? csr_cfg[i][1] : (typ == 2'd2) ? csr_cfg[i][2] : csr_cfg[i][0];
          al    = (mm && !csr_cfg[i][7]) ? 1'b1 : pbit;
        end
        prev = a4;
      end
    end
  endfunction

  task automatic clear_csrs();
    for (int i = 0; i < NB; i++) begin
      csr_addr[i] = '0;
      csr_cfg[i]  = '0;
    end
  endtask

  // Issue one request from an idle checker, wait for the verdict, optionally delay, then ack.
  task automatic do_req(input logic [RLEN-1:0] ad, input logic [1:0] ty, input logic mm,
                        input int delay, output logic m, output logic [IXW-1:0] rg,
                        output logic al, output int lat);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = ad;
    bus.req_type  = ty;
    bus.req_mmode = mm;
    @(posedge aclk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", 0, 1);
    m  = bus.rsp_match;
    rg = bus.rsp_region;
    al = bus.rsp_allow;
    repeat (delay) @(posedge aclk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge aclk);
    #1;
    bus.rsp_ready = 1'b0;
    check("idle_after_ack", bus.req_ready, 1);
  endtask

  logic           m, al, em, eal;
  logic [IXW-1:0] rg;
  int unsigned    erg;
  int             lat;
  logic [RLEN-1:0] hp [4];
  logic [RLEN-1:0] ra;
  logic            seen;

  initial begin
    aresetn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_type  = '0;
    bus.req_mmode = 1'b0;
    bus.rsp_ready = 1'b0;
    clear_csrs();
    #12;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_allow", bus.rsp_allow, 0);
    check("rst_match", bus.rsp_match, 0);
    check("rst_region", bus.rsp_region, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // No entries enabled
    do_req(34'h1000, 2'd0, 1'b0, 0, m, rg, al, lat);
    check("nomatch_u_lat", lat, 16);
    check("nomatch_u_allow", al, 0);
    check("nomatch_u_match", m, 0);
    do_req(34'h1000, 2'd0, 1'b1, 0, m, rg, al, lat);
    check("nomatch_m_allow", al, 1);
    check("nomatch_m_region", rg, 0);

    // NAPOT 4 KiB at 0x1000 on entry 3, read only
    csr_addr[3] = 32'h0000_05FF;
    csr_cfg[3]  = 8'h19;
    do_req(34'h1ABC, 2'd0, 1'b0, 0, m, rg, al, lat);
    check("napot_rd_allow", al, 1);
    check("napot_rd_region", rg, 3);
    check("napot_rd_lat", lat, 4);
    do_req(34'h1ABC, 2'd1, 1'b0, 0, m, rg, al, lat);
    check("napot_wr_allow", al, 0);
    check("napot_wr_match", m, 1);
    do_req(34'h2000, 2'd0, 1'b0, 0, m, rg, al, lat);
    check("napot_out_match", m, 0);

    // TOR priority over a later NA4
    clear_csrs();
    csr_addr[0] = 32'h400;
    csr_addr[1] = 32'h800;
    csr_cfg[1]  = 8'h0C;
    csr_addr[2] = 32'h500;
    csr_cfg[2]  = 8'h11;
    do_req(34'h1400, 2'd2, 1'b0, 0, m, rg, al, lat);
    check("tor_region", rg, 1);
    check("tor_allow", al, 1);
    check("tor_lat", lat, 2);
    do_req(34'h0FFC, 2'd2, 1'b0, 0, m, rg, al, lat);
    check("tor_below_match", m, 0);

    // Lock bit binds M-mode
    clear_csrs();
    csr_addr[0] = 32'h10;
    csr_cfg[0]  = 8'h90;
    do_req(34'h40, 2'd0, 1'b1, 0, m, rg, al, lat);
    check("lock_m_allow", al, 0);
    csr_cfg[0] = 8'h10;
    do_req(34'h40, 2'd0, 1'b1, 0, m, rg, al, lat);
    check("unlock_m_allow", al, 1);

    // Backpressure: verdict held while rsp_ready is low
    bus.req_valid = 1'b1;
    bus.req_addr  = 34'h40;
    bus.req_type  = 2'd1;
    bus.req_mmode = 1'b0;
    @(posedge aclk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge aclk);
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_match", bus.rsp_match, 1);
      check("bp_allow", bus.rsp_allow, 0);
      check("bp_region", bus.rsp_region, 0);
      @(posedge aclk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge aclk);
    #1;
    bus.rsp_ready = 1'b0;

    // Reset in the middle of a scan
    clear_csrs();
    bus.req_valid = 1'b1;
    bus.req_addr  = 34'h1000;
    @(posedge aclk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge aclk);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("midrst_no_rsp", seen, 0);
    check("midrst_idle", bus.req_ready, 1);

    // Whole address space on entry 0
    csr_addr[0] = 32'hFFFF_FFFF;
    csr_cfg[0]  = 8'h19;
    for (int k = 0; k < 4; k++) begin
      ra = {2'($urandom_range(0, 3)), $urandom()};
      do_req(ra, 2'd0, 1'b0, 0, m, rg, al, lat);
      check("all_match", m, 1);
      check("all_region", rg, 0);
      check("all_lat", lat, 1);
      check("all_allow", al, 1);
    end

    // Randomised entries clustered around a few hot addresses
    for (int it = 0; it < 150; it++) begin
      for (int j = 0; j < 4; j++) hp[j] = {2'($urandom_range(0, 3)), $urandom()};
      for (int i = 0; i < NB; i++) begin
        logic [RLEN-1:0] hot;
        logic [XLEN-1:0] v;
        int t;
        hot = hp[$urandom_range(0, 3)];
        v   = XLEN'(hot >> 2);
        csr_cfg[i] = {($urandom_range(0, 3) == 0), 2'b00, 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7))};
        case (csr_cfg[i][4:3])
          2'd1: csr_addr[i] = v + XLEN'($urandom_range(0, 64));
          2'd2: csr_addr[i] = v;
          2'd3: begin
            t = $urandom_range(0, 12);
            csr_addr[i] = (v & ~((32'd1 << (t + 1)) - 1)) | ((32'd1 << t) - 1);
          end
          default: csr_addr[i] = $urandom();
        endcase
      end
      if ($urandom_range(0, 4) == 0) ra = {2'($urandom_range(0, 3)), $urandom()};
      else ra = hp[$urandom_range(0, 3)] + RLEN'($urandom_range(0, 31) * 4);
      begin
        logic [1:0] ty;
        logic mm;
        ty = 2'($urandom_range(0, 3));
        mm = 1'($urandom_range(0, 1));
        model(ra, ty, mm, em, erg, eal);
        do_req(ra, ty, mm, $urandom_range(0, 2), m, rg, al, lat);
      end
      check("rnd_match", m, em);
      check("rnd_region", rg, erg);
      check("rnd_allow", al, eal);
      check("rnd_lat", lat, em ? erg + 1 : NB);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/friscv_pmp_checker.md
# friscv_pmp_checker

Multi-region Physical Memory Protection checker, placed between the load/store and fetch units and their AXI4 masters. It takes a request address, access type and privilege mode, scans up to `NB_REGIONS` PMP entries sequentially, and returns an allow/deny verdict over a valid/ready handshake. It decodes OFF/TOR/NA4/NAPOT regions from the raw `pmpaddr`/`pmpcfg` CSR values, applies lowest-index priority and lock (L) semantics, and exits the scan early on the first match.

## Interface
- `XLEN`, 32: CSR width.
- `RLEN`, 34: physical address width (Sv32 = 34).
- `NB_REGIONS`, 16: number of PMP entries, 1..64.
- `IXW`, `$clog2(NB_REGIONS)` (min 1): width of the region index.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `pmp_addr` in `NB_REGIONS*XLEN`: flattened `pmpaddr` CSRs; entry i is at `[i*XLEN +: XLEN]`.
- `pmp_cfg` in `NB_REGIONS*8`: flattened `pmpcfg` bytes. Bit 0 is R, bit 1 is W, bit 2 is X, bits [4:3] are A, bit 7 is L.
- `req_valid` in 1: check request.
- `req_ready` out 1: checker idle.
- `req_addr` in `RLEN`: byte address to check.
- `req_type` in 2: access type; 0 is read, 1 is write, 2 is exec, 3 is treated as read.
- `req_mmode` in 1: request issued in M-mode.
- `rsp_valid` out 1: verdict available.
- `rsp_ready` in 1: verdict consumed.
- `rsp_allow` out 1: access permitted.
- `rsp_match` out 1: a region matched.
- `rsp_region` out `IXW`: index of the matching region; 0 when there is no match.

## Operation
- The FSM has three states: IDLE, SCAN and RESP.
- **IDLE:**
  - `req_ready` is 1.
  - On `req_valid`, latch `req_addr`, `req_type` and `req_mmode`.
  - Set `idx` to 0 and `prev_top` to 0, then go to SCAN.
- **SCAN:** evaluate entry `idx` combinationally. Let `a = pmp_addr[idx]` and `top = {a, 2'b00}` (zero-extended to `RLEN`).
  - **OFF:** no match.
  - **TOR:** match if `prev_top <= addr < top`. There is no match when `top <= prev_top`.
  - **NA4:** match if `addr[RLEN-1:2] == a`.
  - **NAPOT:**
    - Let t = the number of trailing ones of `a`. The size is `t+3` and `mask = '1 << (t+3)`.
    - Match if `(addr & mask) == ({a, 2'b00} & mask)`.
    - When `a` is all ones, mask is 0 and every address matches.
  - **On a match:**
    - Register `rsp_match=1` and `rsp_region=idx`.
    - `rsp_allow` is 1 if (`req_mmode` and L=0); otherwise it is the R/W/X bit selected by `req_type`.
    - Go to RESP.
  - **On no match:**
    - `prev_top <= top`, for every A encoding, per the privileged spec.
    - `idx <= idx+1`.
    - At `idx == NB_REGIONS-1`, go to RESP with `rsp_match=0`, `rsp_region=0` and `rsp_allow=req_mmode`.
- **RESP:**
  - `rsp_valid` is 1 and all `rsp_*` outputs are held stable.
  - On `rsp_ready`, go to IDLE.
- CSR inputs must be stable from request acceptance to response; the core stalls CSR writes while the checker is busy.
- All comparisons are unsigned in `RLEN` bits. `{a, 2'b00}` uses `XLEN+2` bits truncated or zero-extended to `RLEN`.

## Timing
- **Reset values:** state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_allow=0`, `rsp_match=0`, `rsp_region=0`, `idx=0`, `prev_top=0`.
- `req_ready` is decoded from state only and has no combinational path from `req_valid`.
- **Latency:**
  - With acceptance at edge E0, a match at entry k raises `rsp_valid` after edge E(k+1).
  - With no match, `rsp_valid` rises after edge E(NB_REGIONS).
- **Throughput:**
  - If `rsp_ready=1` in the first RESP cycle, the FSM is IDLE one cycle later.
  - A new request accepted in that cycle starts its scan on the next edge.
  - Worst-case request spacing is `NB_REGIONS+2` cycles.
- **Backpressure:** RESP holds indefinitely while `rsp_ready=0`; `req_ready` stays 0 throughout.
- **Reset mid-scan or mid-RESP:** return to IDLE immediately. No response is emitted and the pending request is dropped.
- **`NB_REGIONS=1`:** SCAN lasts exactly one cycle.

## Test plan
- **Reset and no-match defaults:**
  - Stimulus: all cfg 0, then request read of 0x1000 with `req_mmode=0`.
  - Required: `rsp_valid` after 16 cycles, `allow=0`, `match=0`.
  - Repeat with `req_mmode=1`; required: `allow=1`.
- **NAPOT:**
  - Stimulus: entry 3 `addr=0x000005FF`, cfg A=NAPOT with R=1, W=0. Access 0x1ABC.
  - Required for a read: `allow=1`, `region=3`, latency 4.
  - Required for a write: `allow=0`.
  - Required for 0x2000: no match.
- **TOR with priority:**
  - Stimulus: entry 0 `addr=0x400` OFF; entry 1 `addr=0x800` TOR with X=1; entry 2 NA4 `addr=0x500` with R=1. Exec at 0x1400.
  - Required: `region=1`, `allow=1`.
  - Required for exec at 0x0FFC: entry 2 is not hit and there is no match.
- **Lock in M-mode:**
  - Stimulus: entry 0 NA4 `addr=0x10` with L=1, R=0. M-mode read of 0x40.
  - Required: `allow=0`.
  - With L=0, required: `allow=1`.
- **Handshake and reset:**
  - Hold `rsp_ready=0` for 5 cycles; required: outputs stable and `req_ready=0`.
  - Assert `aresetn=0` during SCAN; required: `rsp_valid` never rises and `req_ready=1` after release.
- **NAPOT whole space:** stimulus `addr=0xFFFFFFFF` on entry 0. Required: any address matches region 0 with latency 1.
